// File: rtl/uart_tx_arbiter_pkg.sv
// Shared types and constants for the UART transmit arbiter and its helpers.
// The arbiter FSM encoding lives beside the transmitter's clocking constants.
package uart_tx_arbiter_pkg;

    localparam int CLOCK_RATE = 50_000_000;
    localparam int BAUD_RATE  = 115_200;
    localparam int BYTE_W     = 8;

    typedef enum logic [1:0] {
        ARB     = 2'd0,
        PRESENT = 2'd1,
        ACK     = 2'd2,
        HOLD    = 2'd3
    } arb_state_t;

endpackage

// File: rtl/uart_rr_pick.sv
// Combinational round-robin picker: first set request after ptr_i, wrapping
// modulo N_REQ. Shared with the receive-side router.
module uart_rr_pick #(
    parameter  int N_REQ = 4,
    localparam int IW    = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
    input  logic [N_REQ-1:0] req_i,
    input  logic [IW-1:0]    ptr_i,
    output logic [IW-1:0]    win_o,
    output logic             any_o
);

    logic [IW-1:0] cand;

    // Scan from the farthest candidate back to the nearest so the nearest wins.
    always_comb begin
        win_o = '0;
        cand  = '0;
        any_o = |req_i;
        for (int k = N_REQ; k >= 1; k--) begin
            cand = IW'((int'(ptr_i) + k) % N_REQ);
            if (req_i[cand]) begin
                win_o = cand;
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter between N_REQ byte sources,
// with optional packet lock and a hold timeout that forces release.
module uart_tx_arbiter
    import uart_tx_arbiter_pkg::*;
#(
    parameter  int N_REQ        = 4,
    parameter  int LOCK_EN      = 1,
    parameter  int LOCK_TIMEOUT = 4096,
    localparam int IW           = (N_REQ > 1) ? $clog2(N_REQ) : 1,
    localparam int CW           = $clog2(LOCK_TIMEOUT + 1)
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [N_REQ-1:0]          req_valid,
    input  logic [BYTE_W*N_REQ-1:0]   req_data,
    input  logic [N_REQ-1:0]          req_last,
    output logic [N_REQ-1:0]          req_ack,
    output logic                      tx_empty,
    output logic [BYTE_W-1:0]         tx_data,
    input  logic                      tx_done,
    output logic [IW-1:0]             grant_idx,
    output logic                      busy,
    output logic                      lock_abort
);

    arb_state_t          state_q, state_d;
    logic [IW-1:0]       grant_q, grant_d;
    logic [IW-1:0]       rr_q, rr_d;
    logic [BYTE_W-1:0]   data_q, data_d;
    logic                last_q, last_d;
    logic                empty_q, empty_d;
    logic [N_REQ-1:0]    ack_q, ack_d;
    logic                busy_q, busy_d;
    logic                abort_q, abort_d;
    logic [CW-1:0]       hold_q, hold_d;

    logic [IW-1:0]       pick_idx;
    logic                pick_any;

    function automatic logic [BYTE_W-1:0] byte_of(
        input logic [BYTE_W*N_REQ-1:0] bus,
        input logic [IW-1:0]           idx
    );
        byte_of = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (idx == IW'(i)) begin
                byte_of = bus[BYTE_W*i +: BYTE_W];
            end
        end
    endfunction

    uart_rr_pick #(
        .N_REQ (N_REQ)
    ) u_pick (
        .req_i (req_valid),
        .ptr_i (rr_q),
        .win_o (pick_idx),
        .any_o (pick_any)
    );

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        rr_d    = rr_q;
        data_d  = data_q;
        last_d  = last_q;
        empty_d = empty_q;
        hold_d  = hold_q;
        ack_d   = '0;
        abort_d = 1'b0;

        unique case (state_q)
            ARB: begin
                empty_d = 1'b1;
                if (pick_any) begin
                    grant_d = pick_idx;
                    data_d  = byte_of(req_data, pick_idx);
                    last_d  = req_last[pick_idx];
                    empty_d = 1'b0;
                    state_d = PRESENT;
                end
            end
            PRESENT: begin
                if (tx_done) begin
                    empty_d        = 1'b1;
                    ack_d[grant_q] = 1'b1;
                    state_d        = ACK;
                end
            end
            ACK: begin
                // Requesters pop on this cycle's edge, so req_valid is stale here.
                if (LOCK_EN == 0 || last_q) begin
                    rr_d    = grant_q;
                    state_d = ARB;
                end else begin
                    hold_d  = '0;
                    state_d = HOLD;
                end
            end
            HOLD: begin
                if (req_valid[grant_q]) begin
                    data_d  = byte_of(req_data, grant_q);
                    last_d  = req_last[grant_q];
                    empty_d = 1'b0;
                    state_d = PRESENT;
                end else begin
                    if (hold_q != {CW{1'b1}}) begin
                        hold_d = hold_q + 1'b1;
                    end
                    if (hold_q >= CW'(LOCK_TIMEOUT - 1)) begin
                        rr_d    = grant_q;
                        abort_d = 1'b1;
                        state_d = ARB;
                    end
                end
            end
            default: begin
                state_d = ARB;
                empty_d = 1'b1;
            end
        endcase

        busy_d = (state_d != ARB);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ARB;
            grant_q <= '0;
            rr_q    <= IW'(N_REQ - 1);
            data_q  <= '0;
            last_q  <= 1'b0;
            empty_q <= 1'b1;
            ack_q   <= '0;
            busy_q  <= 1'b0;
            abort_q <= 1'b0;
            hold_q  <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            rr_q    <= rr_d;
            data_q  <= data_d;
            last_q  <= last_d;
            empty_q <= empty_d;
            ack_q   <= ack_d;
            busy_q  <= busy_d;
            abort_q <= abort_d;
            hold_q  <= hold_d;
        end
    end

    assign req_ack    = ack_q;
    assign tx_empty   = empty_q;
    assign tx_data    = data_q;
    assign grant_idx  = grant_q;
    assign busy       = busy_q;
    assign lock_abort = abort_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: queue-fed requesters, a transmitter model and a
// packet-level round-robin reference for the randomized streams.
module tb_uart_tx_arbiter;

    localparam int N  = 4;
    localparam int LT = 16;

    logic            clk = 1'b0;
    logic            rst_n;
    logic [N-1:0]    req_valid, req_last, req_ack;
    logic [8*N-1:0]  req_data;
    logic            tx_empty, tx_done, busy, lock_abort;
    logic [7:0]      tx_data;
    logic [1:0]      grant_idx;

    int checks = 0;
    int errors = 0;

    // Requester byte queues
    logic [7:0] qb[N][32];
    bit         ql[N][32];
    int         qh[N];
    int         qn[N];

    // Observed transfers
    logic [7:0]   od[64];
    int           og[64];
    logic [N-1:0] oa[64];
    bit           ostab[64];
    bit           oemp[64];
    int           on;
    bit           oto;

    // Expected transfers
    logic [7:0] ed[64];
    int         es[64];
    int         en;

    always #5 clk = ~clk;

    uart_tx_arbiter #(
        .N_REQ        (N),
        .LOCK_EN      (1),
        .LOCK_TIMEOUT (LT)
    ) dut (
        .clk        (clk),
        .reset      (rst_n),
        .req_valid  (req_valid),
        .req_data   (req_data),
        .req_last   (req_last),
        .req_ack    (req_ack),
        .tx_empty   (tx_empty),
        .tx_data    (tx_data),
        .tx_done    (tx_done),
        .grant_idx  (grant_idx),
        .busy       (busy),
        .lock_abort (lock_abort)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic refresh();
        for (int i = 0; i < N; i++) begin
            if (qh[i] < qn[i]) begin
                req_valid[i]      = 1'b1;
                req_data[8*i +: 8] = qb[i][qh[i]];
                req_last[i]       = ql[i][qh[i]];
            end else begin
                req_valid[i]      = 1'b0;
                req_data[8*i +: 8] = 8'h00;
                req_last[i]       = 1'b0;
            end
        end
    endtask

    task automatic clear_q();
        for (int i = 0; i < N; i++) begin
            qh[i] = 0;
            qn[i] = 0;
        end
        refresh();
    endtask

    task automatic push(input int i, input logic [7:0] b, input bit l);
        qb[i][qn[i]] = b;
        ql[i][qn[i]] = l;
        qn[i]++;
    endtask

    task automatic do_reset();
        rst_n   = 1'b0;
        tx_done = 1'b0;
        clear_q();
        tick();
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    // Transmitter model: take a presented byte, wait, pulse txDone, then let
    // the acknowledged requester pop on the edge that ends the ack cycle.
    task automatic run_stream(input int nbytes, input int maxdly);
        on  = 0;
        oto = 1'b0;
        for (int b = 0; b < nbytes; b++) begin
            int  w = 0;
            int  d;
            bit  seen = 1'b0;
            while (!seen && w < 50) begin
                @(negedge clk);
                if (tx_empty === 1'b0) seen = 1'b1;
                else w++;
            end
            if (!seen) begin
                oto = 1'b1;
                return;
            end
            od[on]    = tx_data;
            og[on]    = int'(grant_idx);
            ostab[on] = 1'b1;
            tick();
            d = $urandom_range(0, maxdly);
            for (int k = 0; k <= d; k++) begin
                if (tx_empty !== 1'b0 || tx_data !== od[on]) ostab[on] = 1'b0;
                if (k < d) tick();
            end
            tx_done = 1'b1;
            tick();
            tx_done = 1'b0;
            @(negedge clk);
            oa[on]   = req_ack;
            oemp[on] = tx_empty;
            tick();
            for (int i = 0; i < N; i++) begin
                if (oa[on][i] && qh[i] < qn[i]) qh[i]++;
            end
            refresh();
            on++;
        end
    endtask

    // Packet-level reference: every queued byte is available at once, so the
    // order is whole packets picked round-robin from the queue contents.
    task automatic model(input int start_ptr);
        int mh[N];
        int ptr;
        int src;
        bit l;
        en  = 0;
        ptr = start_ptr;
        for (int i = 0; i < N; i++) mh[i] = qh[i];
        forever begin
            src = -1;
            for (int k = N; k >= 1; k--) begin
                if (mh[(ptr + k) % N] < qn[(ptr + k) % N]) src = (ptr + k) % N;
            end
            if (src < 0) break;
            do begin
                ed[en] = qb[src][mh[src]];
                es[en] = src;
                l      = ql[src][mh[src]];
                mh[src]++;
                en++;
            end while (!l && mh[src] < qn[src]);
            ptr = src;
        end
    endtask

    task automatic test_reset();
        rst_n   = 1'b0;
        tx_done = 1'b0;
        clear_q();
        tick();
        tick();
        @(negedge clk);
        checks++;
        if (tx_empty !== 1'b1 || tx_data !== 8'h00 || req_ack !== 4'b0000) begin
            errors++;
            $display("FAIL reset_tx empty=%b data=%h ack=%b want 1 00 0000", tx_empty, tx_data, req_ack);
        end
        checks++;
        if (grant_idx !== 2'd0 || busy !== 1'b0 || lock_abort !== 1'b0) begin
            errors++;
            $display("FAIL reset_ctl grant=%0d busy=%b abort=%b want 0 0 0", grant_idx, busy, lock_abort);
        end
        tick();
        rst_n = 1'b1;
        tick();
        @(negedge clk);
        checks++;
        if (tx_empty !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_idle empty=%b busy=%b want 1 0", tx_empty, busy);
        end
    endtask

    task automatic test_single();
        do_reset();
        push(1, 8'h55, 1'b1);
        refresh();
        @(negedge clk);
        checks++;
        if (tx_empty !== 1'b1) begin
            errors++;
            $display("FAIL single_registered empty=%b want 1", tx_empty);
        end
        tick();
        @(negedge clk);
        checks++;
        if (tx_empty !== 1'b0 || tx_data !== 8'h55 || grant_idx !== 2'd1 || busy !== 1'b1) begin
            errors++;
            $display("FAIL single_present empty=%b data=%h grant=%0d busy=%b want 0 55 1 1",
                     tx_empty, tx_data, grant_idx, busy);
        end
        begin
            bit stable = 1'b1;
            for (int k = 0; k < 5; k++) begin
                tick();
                if (tx_empty !== 1'b0 || tx_data !== 8'h55 || req_ack !== 4'b0000) stable = 1'b0;
            end
            checks++;
            if (!stable) begin
                errors++;
                $display("FAIL single_hold stable=%b want 1", stable);
            end
        end
        tx_done = 1'b1;
        tick();
        tx_done = 1'b0;
        @(negedge clk);
        checks++;
        if (req_ack !== 4'b0010 || tx_empty !== 1'b1) begin
            errors++;
            $display("FAIL single_ack ack=%b empty=%b want 0010 1", req_ack, tx_empty);
        end
        tick();
        qh[1]++;
        refresh();
        @(negedge clk);
        checks++;
        if (req_ack !== 4'b0000 || busy !== 1'b0 || tx_empty !== 1'b1) begin
            errors++;
            $display("FAIL single_after ack=%b busy=%b empty=%b want 0000 0 1", req_ack, busy, tx_empty);
        end
    endtask

    task automatic test_round_robin();
        do_reset();
        for (int r = 0; r < 3; r++) begin
            for (int i = 0; i < N; i++) push(i, 8'hA0 + 8'(i), 1'b1);
        end
        refresh();
        run_stream(8, 3);
        checks++;
        if (oto || on != 8) begin
            errors++;
            $display("FAIL rr_count got=%0d timeout=%b want 8 0", on, oto);
        end
        for (int k = 0; k < on; k++) begin
            logic [7:0]   xd = 8'hA0 + 8'(k % N);
            logic [N-1:0] xa = 4'(1 << (k % N));
            checks++;
            if (od[k] !== xd || oa[k] !== xa || !ostab[k] || oemp[k] !== 1'b1) begin
                errors++;
                $display("FAIL rr_byte%0d data=%h ack=%b stable=%b empty=%b want %h %b 1 1",
                         k, od[k], oa[k], ostab[k], oemp[k], xd, xa);
            end
        end
    endtask

    task automatic test_packet_lock();
        logic [7:0] xd[5] = '{8'hC0, 8'hC1, 8'hC2, 8'h10, 8'h11};
        int         xg[5] = '{2, 2, 2, 0, 0};
        do_reset();
        push(1, 8'h31, 1'b1);
        refresh();
        run_stream(1, 2);
        checks++;
        if (oto || od[0] !== 8'h31 || og[0] != 1) begin
            errors++;
            $display("FAIL lock_prime data=%h grant=%0d want 31 1", od[0], og[0]);
        end
        push(0, 8'h10, 1'b1);
        push(0, 8'h11, 1'b1);
        push(2, 8'hC0, 1'b0);
        push(2, 8'hC1, 1'b0);
        push(2, 8'hC2, 1'b1);
        refresh();
        run_stream(5, 4);
        checks++;
        if (oto || on != 5) begin
            errors++;
            $display("FAIL lock_count got=%0d timeout=%b want 5 0", on, oto);
        end
        for (int k = 0; k < on; k++) begin
            checks++;
            if (od[k] !== xd[k] || og[k] != xg[k] || oa[k] !== 4'(1 << xg[k])) begin
                errors++;
                $display("FAIL lock_byte%0d data=%h grant=%0d ack=%b want %h %0d",
                         k, od[k], og[k], oa[k], xd[k], xg[k]);
            end
        end
    endtask

    task automatic test_lock_timeout();
        bit hold_ok = 1'b1;
        do_reset();
        push(1, 8'h71, 1'b0);
        push(3, 8'h93, 1'b1);
        refresh();
        run_stream(1, 1);
        checks++;
        if (oto || od[0] !== 8'h71 || og[0] != 1) begin
            errors++;
            $display("FAIL to_first data=%h grant=%0d want 71 1", od[0], og[0]);
        end
        for (int k = 0; k < LT; k++) begin
            @(negedge clk);
            if (busy !== 1'b1 || lock_abort !== 1'b0 || tx_empty !== 1'b1) hold_ok = 1'b0;
            tick();
        end
        checks++;
        if (!hold_ok) begin
            errors++;
            $display("FAIL to_hold held=%b want 1 for %0d cycles", hold_ok, LT);
        end
        @(negedge clk);
        checks++;
        if (lock_abort !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL to_abort abort=%b busy=%b want 1 0", lock_abort, busy);
        end
        tick();
        @(negedge clk);
        checks++;
        if (lock_abort !== 1'b0 || tx_empty !== 1'b0 || grant_idx !== 2'd3 || tx_data !== 8'h93) begin
            errors++;
            $display("FAIL to_next abort=%b empty=%b grant=%0d data=%h want 0 0 3 93",
                     lock_abort, tx_empty, grant_idx, tx_data);
        end
        run_stream(1, 1);
        checks++;
        if (oto || od[0] !== 8'h93 || oa[0] !== 4'b1000) begin
            errors++;
            $display("FAIL to_drain data=%h ack=%b want 93 1000", od[0], oa[0]);
        end
    endtask

    task automatic test_spurious();
        bit seen = 1'b0;
        do_reset();
        tx_done = 1'b1;
        tick();
        tx_done = 1'b0;
        @(negedge clk);
        checks++;
        if (req_ack !== 4'b0000 || busy !== 1'b0 || tx_empty !== 1'b1) begin
            errors++;
            $display("FAIL spur_arb ack=%b busy=%b empty=%b want 0000 0 1", req_ack, busy, tx_empty);
        end
        push(2, 8'h5A, 1'b0);
        refresh();
        run_stream(1, 0);
        tx_done = 1'b1;
        tick();
        tx_done = 1'b0;
        @(negedge clk);
        checks++;
        if (req_ack !== 4'b0000 || busy !== 1'b1 || tx_empty !== 1'b1 || lock_abort !== 1'b0) begin
            errors++;
            $display("FAIL spur_hold ack=%b busy=%b empty=%b abort=%b want 0000 1 1 0",
                     req_ack, busy, tx_empty, lock_abort);
        end
        for (int k = 0; k < 40 && !seen; k++) begin
            tick();
            @(negedge clk);
            if (lock_abort === 1'b1) seen = 1'b1;
        end
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL spur_release abort_seen=%b want 1", seen);
        end
        tick();
    endtask

    task automatic test_async_reset();
        bit any_ack = 1'b0;
        int w = 0;
        do_reset();
        push(1, 8'h11, 1'b1);
        refresh();
        run_stream(1, 0);
        for (int i = 0; i < N; i++) push(i, 8'hE0 + 8'(i), 1'b1);
        refresh();
        @(negedge clk);
        while (tx_empty !== 1'b0 && w < 10) begin
            @(negedge clk);
            w++;
        end
        checks++;
        if (tx_empty !== 1'b0 || grant_idx !== 2'd2) begin
            errors++;
            $display("FAIL ar_pre empty=%b grant=%0d want 0 2", tx_empty, grant_idx);
        end
        #1;
        tx_done = 1'b1;
        rst_n   = 1'b0;
        #1;
        checks++;
        if (tx_empty !== 1'b1 || tx_data !== 8'h00 || req_ack !== 4'b0000 ||
            grant_idx !== 2'd0 || busy !== 1'b0 || lock_abort !== 1'b0) begin
            errors++;
            $display("FAIL ar_clear empty=%b data=%h ack=%b grant=%0d busy=%b abort=%b want 1 00 0000 0 0 0",
                     tx_empty, tx_data, req_ack, grant_idx, busy, lock_abort);
        end
        for (int k = 0; k < 3; k++) begin
            tick();
            if (req_ack !== 4'b0000) any_ack = 1'b1;
        end
        tx_done = 1'b0;
        rst_n   = 1'b1;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            if (req_ack !== 4'b0000) any_ack = 1'b1;
        end
        checks++;
        if (any_ack) begin
            errors++;
            $display("FAIL ar_noack ack_seen=%b want 0", any_ack);
        end
        run_stream(1, 1);
        checks++;
        if (oto || og[0] != 0 || od[0] !== 8'hE0) begin
            errors++;
            $display("FAIL ar_first grant=%0d data=%h want 0 e0", og[0], od[0]);
        end
    endtask

    task automatic test_random();
        for (int r = 0; r < 3; r++) begin
            do_reset();
            for (int i = 0; i < N; i++) begin
                int npk = $urandom_range(0, 3);
                for (int p = 0; p < npk; p++) begin
                    int len = $urandom_range(1, 4);
                    for (int b = 0; b < len; b++) push(i, 8'($urandom), b == len - 1);
                end
            end
            model(N - 1);
            refresh();
            run_stream(en, 4);
            checks++;
            if (oto || on != en) begin
                errors++;
                $display("FAIL rand%0d_count got=%0d timeout=%b want %0d", r, on, oto, en);
            end
            for (int k = 0; k < on; k++) begin
                checks++;
                if (od[k] !== ed[k] || og[k] != es[k] || oa[k] !== 4'(1 << es[k]) || !ostab[k]) begin
                    errors++;
                    $display("FAIL rand%0d_byte%0d data=%h src=%0d ack=%b stable=%b want %h %0d",
                             r, k, od[k], og[k], oa[k], ostab[k], ed[k], es[k]);
                end
            end
            @(negedge clk);
            checks++;
            if (busy !== 1'b0 || tx_empty !== 1'b1 || lock_abort !== 1'b0) begin
                errors++;
                $display("FAIL rand%0d_idle busy=%b empty=%b abort=%b want 0 1 0",
                         r, busy, tx_empty, lock_abort);
            end
        end
    endtask

    initial begin
        rst_n     = 1'b0;
        tx_done   = 1'b0;
        req_valid = '0;
        req_data  = '0;
        req_last  = '0;
        test_reset();
        test_single();
        test_round_robin();
        test_packet_lock();
        test_lock_timeout();
        test_spurious();
        test_async_reset();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500_000;
        $display("FAIL watchdog time=%0t limit reached", $time);
        $fatal(1, "watchdog");
    end

endmodule
